// File: rtl/apb_slave_regbank_pkg.sv
// ----------------------------------------------------------------------------
// apb_slave_regbank_pkg
// Shared definitions for the APB register bank: phase FSM state encodings,
// STATUS register field positions, the write-one-to-clear bit index, and a
// helper that packs the STATUS word.
// ----------------------------------------------------------------------------
package apb_slave_regbank_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam int WR_CNT_LSB = 16;
    localparam int WR_CNT_W   = 16;
    localparam int RD_CNT_LSB = 8;
    localparam int RD_CNT_W   = 8;
    localparam int ERR_BIT    = 0;
    localparam int W1C_BIT    = 0;

    // Full 32-bit STATUS image; narrower buses take the low bits of it.
    function automatic logic [31:0] status_word(input logic [WR_CNT_W-1:0] wr_cnt,
                                                input logic [RD_CNT_W-1:0] rd_cnt,
                                                input logic                err);
        logic [31:0] sw;
        sw = '0;
        sw[WR_CNT_LSB +: WR_CNT_W] = wr_cnt;
        sw[RD_CNT_LSB +: RD_CNT_W] = rd_cnt;
        sw[ERR_BIT]                = err;
        return sw;
    endfunction

endpackage

// File: rtl/apb_phase_fsm.sv
// ----------------------------------------------------------------------------
// apb_phase_fsm
// Tracks the APB IDLE/SETUP/ACCESS phase sequence for one slave select,
// latches the register index and direction in SETUP and checks that they are
// held into the access phase. Produces single-cycle transfer strobes and a
// protocol error pulse; an erroring cycle never produces a transfer.
//
// Ports
//   Hclk, Hresetn    clock, async active-low reset
//   Psel, Penable    APB select / access phase
//   Pwrite           APB direction (1 = write)
//   idx              decoded register index of the current Paddr
//   do_rd, do_wr     transfer strobes, valid on the edge SETUP -> ACCESS
//   err_pulse        protocol violation seen this cycle
//
//   state  | meaning
//   IDLE   | no transfer in progress
//   SETUP  | setup phase seen, index/direction latched
//   ACCESS | transfer performed on entry, lasts one cycle
// ----------------------------------------------------------------------------
module apb_phase_fsm
    import apb_slave_regbank_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic             Hclk,
    input  logic             Hresetn,
    input  logic             Psel,
    input  logic             Penable,
    input  logic             Pwrite,
    input  logic [IDX_W-1:0] idx,
    output logic             do_rd,
    output logic             do_wr,
    output logic             err_pulse
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IDX_W-1:0] lat_idx;
    logic             lat_wr;
    logic             latch;
    logic             match;

    assign match = (idx == lat_idx) && (Pwrite == lat_wr);

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        do_rd     = 1'b0;
        do_wr     = 1'b0;
        err_pulse = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Psel) begin
                    if (!Penable) begin
                        state_nxt = ST_SETUP;
                        latch     = 1'b1;
                    end else begin
                        err_pulse = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (!Psel) begin
                    err_pulse = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (!Penable) begin
                    // Repeated setup: flag it, but follow the new address.
                    err_pulse = 1'b1;
                    latch     = 1'b1;
                end else if (match) begin
                    state_nxt = ST_ACCESS;
                    do_wr     = Pwrite;
                    do_rd     = !Pwrite;
                end else begin
                    err_pulse = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!Psel) begin
                    state_nxt = ST_IDLE;
                end else if (!Penable) begin
                    state_nxt = ST_SETUP;
                    latch     = 1'b1;
                end else begin
                    err_pulse = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state   <= ST_IDLE;
            lat_idx <= '0;
            lat_wr  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch) begin
                lat_idx <= idx;
                lat_wr  <= Pwrite;
            end
        end
    end

endmodule

// File: rtl/apb_slave_regbank.sv
// ----------------------------------------------------------------------------
// apb_slave_regbank
// APB2 slave register bank behind the AHB-to-APB bridge. Holds NREGS-1
// read/write registers plus a STATUS register at index NREGS-1 carrying
// saturating write/read transfer counters and a sticky protocol error flag.
// Writing STATUS with bit 0 set clears the counters and the flag.
//
// Ports
//   Hclk, Hresetn    clock, async active-low reset
//   Psel, Penable    APB select / access phase
//   Pwrite           1 = write, 0 = read
//   Paddr            byte address, index = Paddr[ADDR_LSB +: $clog2(NREGS)]
//   Pwdata           write data
//   Prdata           registered read data, valid in the ACCESS cycle
//   prot_err         sticky protocol error (STATUS[0])
// ----------------------------------------------------------------------------
module apb_slave_regbank
    import apb_slave_regbank_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 8,
    parameter int ADDR_LSB = 2
) (
    input  logic             Hclk,
    input  logic             Hresetn,
    input  logic             Psel,
    input  logic             Penable,
    input  logic             Pwrite,
    input  logic [WIDTH-1:0] Paddr,
    input  logic [WIDTH-1:0] Pwdata,
    output logic [WIDTH-1:0] Prdata,
    output logic             prot_err
);

    localparam int               IDX_W      = $clog2(NREGS);
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NREGS - 1);

    logic [IDX_W-1:0]    idx;
    logic                do_rd;
    logic                do_wr;
    logic                err_pulse;
    logic                status_sel;
    logic                status_clr;
    logic [WIDTH-1:0]    regs [0:NREGS-2];
    logic [WR_CNT_W-1:0] wr_cnt;
    logic [RD_CNT_W-1:0] rd_cnt;
    logic                err_flag;
    logic [31:0]         status_full;
    logic [WIDTH-1:0]    rd_val;
    logic                unused_paddr;

    // Address bits outside the index field are don't-care (aliasing).
    assign idx          = Paddr[ADDR_LSB +: IDX_W];
    assign unused_paddr = ^Paddr;

    apb_phase_fsm #(
        .IDX_W (IDX_W)
    ) u_fsm (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Psel      (Psel),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .idx       (idx),
        .do_rd     (do_rd),
        .do_wr     (do_wr),
        .err_pulse (err_pulse)
    );

    assign status_sel  = (idx == STATUS_IDX);
    assign status_clr  = do_wr && status_sel && Pwdata[W1C_BIT];
    assign status_full = status_word(wr_cnt, rd_cnt, err_flag);
    assign prot_err    = err_flag;

    always_comb begin
        rd_val = '0;
        if (status_sel) begin
            rd_val = status_full[WIDTH-1:0];
        end else begin
            rd_val = regs[idx];
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            for (int i = 0; i < NREGS - 1; i++) begin
                regs[i] <= '0;
            end
        end else if (do_wr && !status_sel) begin
            regs[idx] <= Pwdata;
        end
    end

    // Clear wins over a same-edge increment or error set.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            err_flag <= 1'b0;
        end else if (status_clr) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            err_flag <= 1'b0;
        end else begin
            if (do_wr && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (do_rd && (rd_cnt != '1)) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (err_pulse) begin
                err_flag <= 1'b1;
            end
        end
    end

    // STATUS reads return the counters as they stood before this transfer.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Prdata <= '0;
        end else if (do_rd) begin
            Prdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// ----------------------------------------------------------------------------
// tb_apb_slave_regbank
// Directed bench for apb_slave_regbank: inputs change 1 ns after the rising
// edge, outputs are checked at that same point, away from the edge.
// ----------------------------------------------------------------------------
module tb_apb_slave_regbank;

    logic        Hclk;
    logic        Hresetn;
    logic        Psel;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        prot_err;

    int n_checks;
    int n_fail;

    apb_slave_regbank #(
        .WIDTH    (32),
        .NREGS    (8),
        .ADDR_LSB (2)
    ) dut (
        .Hclk     (Hclk),
        .Hresetn  (Hresetn),
        .Psel     (Psel),
        .Penable  (Penable),
        .Pwrite   (Pwrite),
        .Paddr    (Paddr),
        .Pwdata   (Pwdata),
        .Prdata   (Prdata),
        .prot_err (prot_err)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic setup(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        Psel    = 1'b1;
        Penable = 1'b0;
        Pwrite  = wr;
        Paddr   = addr;
        Pwdata  = data;
        tick();
    endtask

    task automatic access();
        Penable = 1'b1;
        tick();
    endtask

    task automatic idle();
        Psel    = 1'b0;
        Penable = 1'b0;
        tick();
    endtask

    task automatic wr_xfer(input logic [31:0] addr, input logic [31:0] data);
        setup(1'b1, addr, data);
        access();
        idle();
    endtask

    // Leaves the bus in the ACCESS cycle so Prdata can be checked.
    task automatic rd_xfer(input logic [31:0] addr);
        setup(1'b0, addr, 32'h0);
        access();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Hresetn  = 1'b0;
        Psel     = 1'b0;
        Penable  = 1'b0;
        Pwrite   = 1'b0;
        Paddr    = '0;
        Pwdata   = '0;
        repeat (3) tick();
        Hresetn = 1'b1;
        tick();

        chk("reset_prdata", Prdata, 32'h0);
        chk("reset_err", {31'b0, prot_err}, 32'h0);

        // 1: simple write/read and STATUS counters
        wr_xfer(32'h04, 32'hA5A5_0001);
        rd_xfer(32'h04);
        chk("t1_rd04", Prdata, 32'hA5A5_0001);
        idle();
        rd_xfer(32'h1C);
        chk("t1_status", Prdata, 32'h0001_0100);
        idle();

        // 2: back-to-back write then read, no IDLE between
        setup(1'b1, 32'h08, 32'h0000_1234);
        access();
        rd_xfer(32'h08);
        chk("t2_b2b_rd08", Prdata, 32'h0000_1234);
        idle();

        // aliasing: 0x24 hits index 1; 0x05 also index 1
        wr_xfer(32'h24, 32'hDEAD_BEEF);
        rd_xfer(32'h05);
        chk("alias_rd", Prdata, 32'hDEAD_BEEF);
        idle();
        rd_xfer(32'h1C);
        chk("status_3w4r", Prdata, 32'h0003_0400);
        idle();

        // 3: Penable without setup in IDLE
        Psel    = 1'b1;
        Penable = 1'b1;
        Pwrite  = 1'b1;
        Paddr   = 32'h08;
        Pwdata  = 32'hFFFF_FFFF;
        tick();
        chk("t3_err", {31'b0, prot_err}, 32'h1);
        idle();
        rd_xfer(32'h08);
        chk("t3_rd08", Prdata, 32'h0000_1234);
        idle();

        // 4: address changes between SETUP and ACCESS
        setup(1'b1, 32'h04, 32'h5555_5555);
        Paddr   = 32'h0C;
        Penable = 1'b1;
        tick();
        idle();
        rd_xfer(32'h04);
        chk("t4_rd04", Prdata, 32'hDEAD_BEEF);
        idle();
        rd_xfer(32'h0C);
        chk("t4_rd0c", Prdata, 32'h0);
        idle();

        // STATUS write with bit0=0: counted, no clear
        wr_xfer(32'h1C, 32'hFFFF_FFFE);
        chk("w0_err_kept", {31'b0, prot_err}, 32'h1);
        rd_xfer(32'h1C);
        chk("status_4w8r_err", Prdata, 32'h0004_0801);
        idle();

        // 5: W1C clear
        wr_xfer(32'h1C, 32'h0000_0001);
        chk("t5_err_clr", {31'b0, prot_err}, 32'h0);
        rd_xfer(32'h1C);
        chk("t5_status_a", Prdata, 32'h0000_0000);
        idle();
        rd_xfer(32'h1C);
        chk("t5_status_b", Prdata, 32'h0000_0100);
        idle();

        // rd_cnt saturation: 300 more reads -> 255
        for (int i = 0; i < 300; i++) begin
            rd_xfer(32'h00);
        end
        idle();
        rd_xfer(32'h1C);
        chk("rd_sat", Prdata, 32'h0000_FF00);
        idle();
        wr_xfer(32'h00, 32'h0000_CAFE);
        rd_xfer(32'h1C);
        chk("rd_sat_hold", Prdata, 32'h0001_FF00);
        idle();

        // 6: reset during ACCESS of a write to 0x00
        Psel    = 1'b1;
        Penable = 1'b1;
        tick();
        chk("t6_pre_err", {31'b0, prot_err}, 32'h1);
        idle();
        setup(1'b1, 32'h00, 32'h0000_0077);
        access();
        Hresetn = 1'b0;
        #2;
        chk("t6_rst_prdata", Prdata, 32'h0);
        chk("t6_rst_err", {31'b0, prot_err}, 32'h0);
        Psel    = 1'b0;
        Penable = 1'b0;
        tick();
        Hresetn = 1'b1;
        tick();
        rd_xfer(32'h00);
        chk("t6_rd00", Prdata, 32'h0);
        idle();
        rd_xfer(32'h1C);
        chk("t6_status", Prdata, 32'h0000_0100);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
